// File: rtl/packet_filter_ex.sv
// rtl/packet_filter_ex.sv - store-and-forward AXI-Stream filter with per-packet verdict
// Buffers whole packets, then forwards, marks or flushes them; keeps saturating counters.
module packet_filter_ex #(
    parameter int DW             = 512,
    parameter int FIFO_DEPTH     = 256,
    parameter int MAX_BEATS      = 64,
    parameter int MARK_ONLY_MODE = 0,
    parameter int CW             = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   AXIS_IN_TDATA,
    input  logic [DW/8-1:0] AXIS_IN_TKEEP,
    input  logic            AXIS_IN_TUSER,
    input  logic            AXIS_IN_TLAST,
    input  logic            AXIS_IN_TVALID,
    output logic            AXIS_IN_TREADY,
    output logic [DW-1:0]   AXIS_OUT_TDATA,
    output logic [DW/8-1:0] AXIS_OUT_TKEEP,
    output logic            AXIS_OUT_TUSER,
    output logic            AXIS_OUT_TLAST,
    output logic            AXIS_OUT_TVALID,
    input  logic            AXIS_OUT_TREADY,
    input  logic            clear_counts,
    output logic            bad_packet_strb,
    output logic            trunc_strb,
    output logic [CW-1:0]   good_count,
    output logic [CW-1:0]   bad_count,
    output logic [CW-1:0]   trunc_count
);
    localparam int KW  = DW / 8;
    localparam int FW  = DW + KW + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BCW = $clog2(MAX_BEATS + 1);

    typedef enum logic {ST_PASS, ST_DISCARD} state_t;

    state_t          state_q, state_d;
    logic            err_q, err_d;
    logic [BCW-1:0]  bc_q, bc_d;

    logic [FW-1:0]   data_mem_q [FIFO_DEPTH];
    logic [AW-1:0]   d_wr_ptr_q, d_wr_ptr_d, d_rd_ptr_q, d_rd_ptr_d;
    logic [AW:0]     d_cnt_q, d_cnt_d;

    logic [FIFO_DEPTH-1:0] eop_mem_q, eop_mem_d;
    logic [AW-1:0]   e_wr_ptr_q, e_wr_ptr_d, e_rd_ptr_q, e_rd_ptr_d;
    logic [AW:0]     e_cnt_q, e_cnt_d;

    logic [CW-1:0]   good_q, good_d, bad_q, bad_d, trunc_q, trunc_d;
    logic            bad_strb_q, bad_strb_d, trunc_strb_q, trunc_strb_d;

    logic            d_full, in_fire, d_push, d_pop, wr_last;
    logic            eop_push, eop_verdict, eop_pop, trunc_ev;
    logic            eop_valid, head_v, fwd;
    logic [FW-1:0]   head;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign d_full         = (d_cnt_q == (AW+1)'(FIFO_DEPTH));
    assign AXIS_IN_TREADY = !reset && ((state_q == ST_DISCARD) || !d_full);
    assign in_fire        = AXIS_IN_TVALID && AXIS_IN_TREADY;

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        bc_d        = bc_q;
        d_push      = 1'b0;
        wr_last     = AXIS_IN_TLAST;
        eop_push    = 1'b0;
        eop_verdict = 1'b0;
        trunc_ev    = 1'b0;
        case (state_q)
            ST_PASS: begin
                if (in_fire) begin
                    d_push = 1'b1;
                    if (AXIS_IN_TLAST) begin
                        eop_push    = 1'b1;
                        eop_verdict = err_q | AXIS_IN_TUSER;
                        err_d       = 1'b0;
                        bc_d        = '0;
                    end else if (bc_q == BCW'(MAX_BEATS - 1)) begin
                        // Over-length: close the stored packet here and swallow the rest.
                        wr_last     = 1'b1;
                        eop_push    = 1'b1;
                        eop_verdict = 1'b1;
                        trunc_ev    = 1'b1;
                        err_d       = 1'b0;
                        bc_d        = '0;
                        state_d     = ST_DISCARD;
                    end else begin
                        err_d = err_q | AXIS_IN_TUSER;
                        bc_d  = bc_q + 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (in_fire && AXIS_IN_TLAST) state_d = ST_PASS;
            end
            default: state_d = ST_PASS;
        endcase
    end

    assign eop_valid = (e_cnt_q != '0);
    assign head_v    = eop_mem_q[e_rd_ptr_q];
    assign head      = data_mem_q[d_rd_ptr_q];
    assign fwd       = !head_v || (MARK_ONLY_MODE != 0);

    assign AXIS_OUT_TVALID = !reset && eop_valid && fwd;
    assign AXIS_OUT_TDATA  = head[FW-1 -: DW];
    assign AXIS_OUT_TKEEP  = head[KW:1];
    assign AXIS_OUT_TLAST  = head[0];
    assign AXIS_OUT_TUSER  = eop_valid && head_v;

    // Dropped packets drain one beat per cycle without waiting on the consumer.
    assign d_pop   = eop_valid && (fwd ? AXIS_OUT_TREADY : 1'b1);
    assign eop_pop = d_pop && head[0];

    always_comb begin
        d_wr_ptr_d = d_push ? d_wr_ptr_q + 1'b1 : d_wr_ptr_q;
        d_rd_ptr_d = d_pop  ? d_rd_ptr_q + 1'b1 : d_rd_ptr_q;
        case ({d_push, d_pop})
            2'b10:   d_cnt_d = d_cnt_q + 1'b1;
            2'b01:   d_cnt_d = d_cnt_q - 1'b1;
            default: d_cnt_d = d_cnt_q;
        endcase
        eop_mem_d = eop_mem_q;
        if (eop_push) eop_mem_d[e_wr_ptr_q] = eop_verdict;
        e_wr_ptr_d = eop_push ? e_wr_ptr_q + 1'b1 : e_wr_ptr_q;
        e_rd_ptr_d = eop_pop  ? e_rd_ptr_q + 1'b1 : e_rd_ptr_q;
        case ({eop_push, eop_pop})
            2'b10:   e_cnt_d = e_cnt_q + 1'b1;
            2'b01:   e_cnt_d = e_cnt_q - 1'b1;
            default: e_cnt_d = e_cnt_q;
        endcase
    end

    always_comb begin
        good_d       = good_q;
        bad_d        = bad_q;
        trunc_d      = trunc_q;
        bad_strb_d   = eop_push && eop_verdict;
        trunc_strb_d = trunc_ev;
        if (clear_counts) begin
            good_d  = '0;
            bad_d   = '0;
            trunc_d = '0;
        end else if (eop_push) begin
            if (eop_verdict) bad_d   = sat_inc(bad_q);
            else             good_d  = sat_inc(good_q);
            if (trunc_ev)    trunc_d = sat_inc(trunc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (d_push) data_mem_q[d_wr_ptr_q] <= {AXIS_IN_TDATA, AXIS_IN_TKEEP, wr_last};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_PASS;
            err_q        <= 1'b0;
            bc_q         <= '0;
            d_wr_ptr_q   <= '0;
            d_rd_ptr_q   <= '0;
            d_cnt_q      <= '0;
            eop_mem_q    <= '0;
            e_wr_ptr_q   <= '0;
            e_rd_ptr_q   <= '0;
            e_cnt_q      <= '0;
            good_q       <= '0;
            bad_q        <= '0;
            trunc_q      <= '0;
            bad_strb_q   <= 1'b0;
            trunc_strb_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            bc_q         <= bc_d;
            d_wr_ptr_q   <= d_wr_ptr_d;
            d_rd_ptr_q   <= d_rd_ptr_d;
            d_cnt_q      <= d_cnt_d;
            eop_mem_q    <= eop_mem_d;
            e_wr_ptr_q   <= e_wr_ptr_d;
            e_rd_ptr_q   <= e_rd_ptr_d;
            e_cnt_q      <= e_cnt_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            trunc_q      <= trunc_d;
            bad_strb_q   <= bad_strb_d;
            trunc_strb_q <= trunc_strb_d;
        end
    end

    assign good_count      = good_q;
    assign bad_count       = bad_q;
    assign trunc_count     = trunc_q;
    assign bad_packet_strb = bad_strb_q;
    assign trunc_strb      = trunc_strb_q;
endmodule

// File: tb/tb_packet_filter_ex.sv
// tb/tb_packet_filter_ex.sv - self-checking bench for packet_filter_ex
// Three filters (drop/MAX 16, mark/MAX 4, drop/MAX 4) share one broadcast input stream.
module tb_packet_filter_ex;
    localparam int NDUT = 3;
    localparam int DW   = 32;
    localparam int KW   = 4;
    localparam int CMAX = 15;

    function automatic int mb_of(input int k);
        return (k == 0) ? 16 : 4;
    endfunction
    function automatic int mk_of(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0]   in_tdata = '0;
    logic [KW-1:0]   in_tkeep = '0;
    logic            in_tuser = 1'b0, in_tlast = 1'b0;
    logic [NDUT-1:0] in_tvalid = '0, in_tready;
    logic [DW-1:0]   out_tdata [NDUT];
    logic [KW-1:0]   out_tkeep [NDUT];
    logic [NDUT-1:0] out_tuser, out_tlast, out_tvalid, bad_strb, trunc_strb;
    logic            out_ready = 1'b0;
    logic            clear_counts = 1'b0;
    logic [3:0]      good_c [NDUT], bad_c [NDUT], trunc_c [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        packet_filter_ex #(
            .DW(DW), .FIFO_DEPTH(16), .MAX_BEATS(mb_of(g)),
            .MARK_ONLY_MODE(mk_of(g)), .CW(4)
        ) u_dut (
            .clk(clk), .reset(reset),
            .AXIS_IN_TDATA(in_tdata), .AXIS_IN_TKEEP(in_tkeep), .AXIS_IN_TUSER(in_tuser),
            .AXIS_IN_TLAST(in_tlast), .AXIS_IN_TVALID(in_tvalid[g]), .AXIS_IN_TREADY(in_tready[g]),
            .AXIS_OUT_TDATA(out_tdata[g]), .AXIS_OUT_TKEEP(out_tkeep[g]), .AXIS_OUT_TUSER(out_tuser[g]),
            .AXIS_OUT_TLAST(out_tlast[g]), .AXIS_OUT_TVALID(out_tvalid[g]), .AXIS_OUT_TREADY(out_ready),
            .clear_counts(clear_counts), .bad_packet_strb(bad_strb[g]), .trunc_strb(trunc_strb[g]),
            .good_count(good_c[g]), .bad_count(bad_c[g]), .trunc_count(trunc_c[g])
        );
    end

    int n_total = 0;
    int n_bad   = 0;
    int rdy_mode = 1;

    logic [DW+KW+1:0] exp_mem [NDUT][1024];
    int exp_wr [NDUT] = '{0, 0, 0};
    int exp_rd [NDUT] = '{0, 0, 0};
    int m_good [NDUT] = '{0, 0, 0};
    int m_bad  [NDUT] = '{0, 0, 0};
    int m_trunc[NDUT] = '{0, 0, 0};
    int m_bs   [NDUT] = '{0, 0, 0};
    int m_ts   [NDUT] = '{0, 0, 0};
    int seen_bs[NDUT] = '{0, 0, 0};
    int seen_ts[NDUT] = '{0, 0, 0};
    logic [NDUT-1:0]  held = '0;
    logic [DW+KW+1:0] held_beat [NDUT];

    always @(posedge clk) begin
        #1;
        out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end

    always @(negedge clk) begin
        if (reset) begin
            held = '0;
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                logic [DW+KW+1:0] cur;
                cur = {out_tdata[k], out_tkeep[k], out_tuser[k], out_tlast[k]};
                if (bad_strb[k])   seen_bs[k]++;
                if (trunc_strb[k]) seen_ts[k]++;
                if (held[k]) begin
                    n_total++;
                    assert (out_tvalid[k] === 1'b1 && cur === held_beat[k]) else begin
                        n_bad++;
                        $error("FAIL stall_hold dut%0d got v=%b beat=%h want v=1 beat=%h",
                               k, out_tvalid[k], cur, held_beat[k]);
                    end
                end
                if (out_tvalid[k] && out_ready) begin
                    n_total++;
                    assert (exp_rd[k] < exp_wr[k]) else begin
                        n_bad++;
                        $error("FAIL unexpected_beat dut%0d got=%h want=none", k, cur);
                    end
                    if (exp_rd[k] < exp_wr[k]) begin
                        n_total++;
                        assert (cur === exp_mem[k][exp_rd[k]]) else begin
                            n_bad++;
                            $error("FAIL out_beat dut%0d idx=%0d got=%h want=%h",
                                   k, exp_rd[k], cur, exp_mem[k][exp_rd[k]]);
                        end
                        exp_rd[k]++;
                    end
                end
                held[k] = out_tvalid[k] && !out_ready;
                held_beat[k] = cur;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic check_counts(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("%s_good%0d", tag, k),  32'(good_c[k]),  32'(m_good[k]));
            chk($sformatf("%s_bad%0d", tag, k),   32'(bad_c[k]),   32'(m_bad[k]));
            chk($sformatf("%s_trunc%0d", tag, k), 32'(trunc_c[k]), 32'(m_trunc[k]));
        end
    endtask

    task automatic zero_model();
        for (int k = 0; k < NDUT; k++) begin
            m_good[k] = 0; m_bad[k] = 0; m_trunc[k] = 0;
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] kp,
                             input logic u, input logic l);
        logic [NDUT-1:0] acc;
        in_tdata = d; in_tkeep = kp; in_tuser = u; in_tlast = l;
        in_tvalid = '1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            acc = in_tvalid & in_tready;
            @(posedge clk);
            #1;
            in_tvalid = in_tvalid & ~acc;
            if (in_tvalid == '0) return;
        end
        n_total++;
        n_bad++;
        $error("FAIL accept_timeout got pending=%b want=000", in_tvalid);
        in_tvalid = '0;
    endtask

    task automatic send_packet(input int n, input logic [31:0] umask);
        logic [DW-1:0] d  [32];
        logic [KW-1:0] kp [32];
        for (int i = 0; i < n; i++) begin
            d[i]  = $urandom;
            kp[i] = 4'($urandom_range(1, 15));
        end
        for (int k = 0; k < NDUT; k++) begin
            int   stored;
            logic trunc, isbad;
            trunc  = (n > mb_of(k));
            isbad  = trunc || (umask != 0);
            stored = trunc ? mb_of(k) : n;
            if (!isbad || mk_of(k) == 1) begin
                for (int i = 0; i < stored; i++) begin
                    exp_mem[k][exp_wr[k]] = {d[i], kp[i], isbad, 1'(i == stored - 1)};
                    exp_wr[k]++;
                end
            end
            if (isbad) begin
                m_bad[k] = (m_bad[k] < CMAX) ? m_bad[k] + 1 : CMAX;
                m_bs[k]++;
            end else begin
                m_good[k] = (m_good[k] < CMAX) ? m_good[k] + 1 : CMAX;
            end
            if (trunc) begin
                m_trunc[k] = (m_trunc[k] < CMAX) ? m_trunc[k] + 1 : CMAX;
                m_ts[k]++;
            end
        end
        for (int i = 0; i < n; i++) send_beat(d[i], kp[i], umask[i], 1'(i == n - 1));
    endtask

    function automatic logic all_drained();
        for (int k = 0; k < NDUT; k++) if (exp_rd[k] != exp_wr[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string tag);
        rdy_mode = 1;
        for (int t = 0; t < 600; t++) begin
            if (all_drained()) break;
            @(posedge clk);
            #1;
        end
        chk({tag, "_drained"}, 32'(all_drained()), 32'd1);
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("reset_in_tready", 32'(in_tready), 32'd0);
        chk("reset_out_tvalid", 32'(out_tvalid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_tready", 32'(in_tready), 32'b111);
        chk("post_reset_strobes", 32'({bad_strb, trunc_strb}), 32'd0);
        check_counts("reset");
        @(posedge clk);
        #1;

        for (int p = 0; p < 3; p++) begin
            send_packet(4, 32'd0);
            if (p == 0) chk("first_out_latency", 32'(out_tvalid), 32'b111);
        end
        drain("clean");
        check_counts("clean");

        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send_packet(5, 32'b00010);
        chk("drop_hidden_n1", 32'(out_tvalid[0]), 32'd0);
        chk("mark_shown_n1", 32'(out_tvalid[1]), 32'd1);
        send_packet(2, 32'd0);
        chk("drop_flush_n3", 32'(out_tvalid[0]), 32'd0);
        @(posedge clk); #1;
        chk("drop_flush_n4", 32'(out_tvalid[0]), 32'd0);
        @(posedge clk); #1;
        chk("drop_flush_n5", 32'(out_tvalid[0]), 32'd0);
        @(posedge clk); #1;
        chk("drop_flush_done_n6", 32'(out_tvalid[0]), 32'd1);
        drain("mid_err");
        check_counts("mid_err");

        send_packet(7, 32'd0);
        send_packet(19, 32'd0);
        drain("trunc");
        check_counts("trunc");

        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send_packet(16, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_tready_low", 32'(in_tready[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        send_packet(4, 32'd0);
        drain("backpressure");
        check_counts("backpressure");

        rdy_mode = 2;
        for (int p = 0; p < 30; p++) begin
            int n;
            logic [31:0] m;
            n = $urandom_range(1, 6);
            m = ($urandom_range(0, 3) == 0) ? (32'd1 << $urandom_range(0, n - 1)) : 32'd0;
            send_packet(n, m);
        end
        drain("random");
        check_counts("random");

        clear_counts = 1'b1;
        @(posedge clk);
        #1;
        clear_counts = 1'b0;
        zero_model();
        check_counts("clear");
        for (int p = 0; p < 17; p++) send_packet(1, 32'd0);
        drain("saturate");
        check_counts("saturate");
        chk("saturate_good0", 32'(good_c[0]), 32'd15);

        clear_counts = 1'b1;
        send_packet(1, 32'd0);
        clear_counts = 1'b0;
        zero_model();
        check_counts("clear_vs_push");
        drain("clear_vs_push");

        for (int i = 0; i < 3; i++) send_beat($urandom, 4'hf, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_in_tready", 32'(in_tready), 32'd0);
        chk("midreset_out_tvalid", 32'(out_tvalid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        zero_model();
        @(negedge clk);
        check_counts("midreset");
        @(posedge clk);
        #1;
        send_packet(3, 32'd0);
        drain("after_reset");
        check_counts("after_reset");

        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("bad_strb_pulses%0d", k), 32'(seen_bs[k]), 32'(m_bs[k]));
            chk($sformatf("trunc_strb_pulses%0d", k), 32'(seen_ts[k]), 32'(m_ts[k]));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
